// File: rtl/demux_1x8_rr_sched.sv
// Round-robin dispatcher in front of the demux_1x8 datapath: one-entry holding buffer,
// steered to the next enabled/ready channel. Optional stall-skip: define DMUX_RR_SKIP_EN.

module demux_1x8 (
   input  logic       i,
   input  logic [2:0] s,
   output logic [7:0] o
);
   always_comb begin
      o    = '0;
      o[s] = i;
   end
endmodule

module demux_1x8_rr_sched #(
   parameter int DW = 8,
   parameter int CW = 16
`ifdef DMUX_RR_SKIP_EN
   ,
   parameter int TMO = 4
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic [7:0]    ch_en,
   input  logic [7:0]    out_ready,
   output logic [7:0]    out_valid,
   output logic [DW-1:0] out_data,
   output logic [2:0]    sel,
   output logic          busy,
   output logic [CW-1:0] xfer_cnt
`ifdef DMUX_RR_SKIP_EN
   ,
   output logic [CW-1:0] skip_cnt
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t        state_q, state_d;
   logic [2:0]    sel_q, sel_d, ptr_q, ptr_d;
   logic [DW-1:0] data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic       hold_valid, any_en, fire, cap;
   logic [2:0] scan_base, pick;

   // First enabled channel scanning circularly from base; returns base if none.
   function automatic logic [2:0] rr_pick(input logic [7:0] en, input logic [2:0] base);
      logic [2:0] r, idx;
      r = base;
      for (int k = 7; k >= 0; k--) begin
         idx = base + 3'(k);
         if (en[idx]) r = idx;
      end
      return r;
   endfunction

   assign hold_valid = (state_q == FULL);
   assign any_en     = |ch_en;
   assign fire       = hold_valid & out_ready[sel_q] & ch_en[sel_q];
   assign in_ready   = rst_n & any_en & (~hold_valid | fire);
   assign cap        = in_valid & in_ready;
   // On a same-cycle fire the pointer has effectively moved past sel already.
   assign scan_base  = fire ? sel_q + 3'd1 : ptr_q;
   assign pick       = rr_pick(ch_en, scan_base);

   demux_1x8 u_demux (
      .i (hold_valid),
      .s (sel_q),
      .o (out_valid)
   );

   assign out_data = data_q;
   assign sel      = sel_q;
   assign busy     = hold_valid;
   assign xfer_cnt = cnt_q;

`ifdef DMUX_RR_SKIP_EN
   localparam int WW = (TMO < 2) ? 1 : $clog2(TMO);

   logic [WW-1:0] wait_q, wait_d;
   logic [CW-1:0] skip_q, skip_d;
   logic [2:0]    nxt;
   logic          alt, timeout;

   assign nxt     = rr_pick(ch_en, sel_q + 3'd1);
   assign alt     = ch_en[nxt] & (nxt != sel_q);
   assign timeout = hold_valid & ~fire & (wait_q == WW'(TMO - 1)) & alt;
   assign skip_cnt = skip_q;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
`ifdef DMUX_RR_SKIP_EN
      skip_d  = skip_q;
      wait_d  = wait_q;
      if (hold_valid && !fire && wait_q != WW'(TMO - 1)) wait_d = wait_q + 1'b1;
`endif
      if (fire) begin
         cnt_d = cnt_q + 1'b1;
         ptr_d = sel_q + 3'd1;
      end
      if (cap) begin
         state_d = FULL;
         data_d  = in_data;
         sel_d   = pick;
`ifdef DMUX_RR_SKIP_EN
         wait_d  = '0;
`endif
      end else if (fire) begin
         state_d = EMPTY;
      end else if (hold_valid && !ch_en[sel_q] && any_en) begin
         sel_d = pick;
`ifdef DMUX_RR_SKIP_EN
         wait_d = '0;
      end else if (timeout) begin
         sel_d  = nxt;
         skip_d = skip_q + 1'b1;
         wait_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         sel_q   <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
`ifdef DMUX_RR_SKIP_EN
         wait_q  <= '0;
         skip_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
`ifdef DMUX_RR_SKIP_EN
         wait_q  <= wait_d;
         skip_q  <= skip_d;
`endif
      end
   end

endmodule

// File: doc/demux_1x8_rr_sched.md
Name: demux_1x8_rr_sched

Overview:
- Round-robin dispatcher that sequences the existing demux_1x8 datapath.
- Accepts a single valid/ready input stream and holds each word in a one-entry buffer.
- Steers each word to the next enabled, ready output channel among 8 by driving the demux select.
- Sits in front of 8 consumer channels (workers or lanes) that share one producer.

Parameters:
- DW, 8, data width of in_data/out_data.
- CW, 16, width of the transfer counter xfer_cnt.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_data  input  DW  producer word.
- in_ready  output  1  block accepts in_data this cycle.
- ch_en  input  8  per-channel enable mask; bit k=1 makes channel k eligible.
- out_ready  input  8  per-channel consumer ready.
- out_valid  output  8  one-hot valid to channel sel (all zero when empty).
- out_data  output  DW  held word, broadcast to all channels.
- sel  output  3  current demux select (channel index of held word).
- busy  output  1  buffer holds a word.
- xfer_cnt  output  CW  count of completed output transfers.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous, active-low, and is the only reset.
- Reset values: hold_valid=0, sel=0, ptr=0, out_data=0, xfer_cnt=0, state=EMPTY. Outputs follow: in_ready=0 while rst_n=0, out_valid=0, busy=0.
- State machine: EMPTY (hold_valid=0) and FULL (hold_valid=1). busy=1 exactly in FULL.
- Demux instance: out_valid comes from an instance of demux_1x8 with i=hold_valid and s=sel. The result is one-hot or all zero.
- fire: fire = hold_valid & out_ready[sel] & ch_en[sel].
- Eligible channel: pick = first k with ch_en[k]=1, scanning circularly from ptr (ptr, ptr+1, ..., 7, 0, ..., ptr-1). any_en = |ch_en.
- in_ready: in_ready = any_en & (~hold_valid | fire). Back-to-back throughput is 1 word/cycle.
- Capture: when in_valid & in_ready:
  - hold_valid<=1, out_data<=in_data.
  - sel<=pick, computed with ptr already advanced if fire occurs in the same cycle. That is, on a simultaneous fire and capture, the scan starts at sel+1.
- Fire without capture: hold_valid<=0. ptr<=sel+1, wrapping 7->0. sel keeps its value.
- xfer_cnt: increments by 1 on every fire and wraps modulo 2^CW.
- Latency: input accept to out_valid is 1 cycle. A word is held until fire, with no timeout in the base build.
- Channel disabled while FULL: if ch_en[sel]=0 while FULL, sel<=pick on the next edge (scan from ptr) if any_en=1. out_data is kept and the transfer does not fire.
- All channels disabled: if ch_en=0 while FULL, the word stays held, sel is unchanged, and in_ready=0.
- Wrap-around: ptr and sel are 3-bit and wrap naturally. With ch_en=8'b1000_0001 and ptr=7, sel=7; the next word goes to channel 0.
- Input data: in_data is ignored when in_valid=0. out_data is stable while FULL and not firing.
- Reset mid-operation: an asynchronous assert drops the held word immediately. All registers return to their reset values and there is no output glitch beyond out_valid going to 0.

Optional Feature:
- Macro: DMUX_RR_SKIP_EN.
- Defined: adds parameter TMO (default 4) and a wait counter that clears on capture or reassignment.
  - If FULL and the transfer does not fire for TMO consecutive cycles, sel<=next eligible channel after sel, scanning from sel+1. Reassignment happens only when another eligible channel exists.
  - The wait counter resets on each reassignment.
  - Adds output skip_cnt (CW), which increments per reassignment.
- Undefined: no counter and no skip_cnt port. A word waits indefinitely on its channel.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, xfer_cnt=0. Release rst_n, ch_en=FF, out_ready=FF, send 8 words 0x10..0x17 back-to-back -> word n appears on out_valid[n] one cycle after acceptance, in_ready stays 1, xfer_cnt=8.
- Sparse mask: ch_en=8'b1010_0100, out_ready=FF, send 6 words -> channels 2, 5, 7, 2, 5, 7.
- Backpressure: ch_en=FF, out_ready[0]=0 for 5 cycles, send 0xA5 -> out_valid=01 held for 5 cycles, out_data=0xA5, in_ready=0. Raise out_ready[0] -> fire, and the next word goes to channel 1.
- Mask change while FULL: word held on channel 3 with out_ready[3]=0, then clear ch_en[3] -> sel becomes 4 the next cycle and the word fires on channel 4. With ch_en=0, the word holds and in_ready=0.
- Asynchronous reset mid-transfer: assert rst_n=0 while FULL, between clock edges -> out_valid=0, busy=0 immediately. After release, the first word goes to channel 0.
- With DMUX_RR_SKIP_EN and TMO=4: out_ready[0]=0, others 1 -> word reassigned to channel 1 after 4 stalled cycles, skip_cnt=1.
